// File: rtl/dual_grant_rr_arbiter_if.sv
// rtl/dual_grant_rr_arbiter_if.sv - request/grant bundle between requester bank, arbiter and shared resource
//
// Signals (named from the arbiter's point of view):
//   req_i        WIDTH  request vector, bit k is requester k
//   gnt_ready_i  1      downstream accepts the presented grant
//   gnt_valid_o  1      a grant is being presented
//   gnt0_o       WIDTH  one-hot first grant, zero when idle
//   gnt1_o       WIDTH  one-hot second grant, zero when fewer than two granted
//   gnt_cnt_o    2      number of grants presented (0, 1 or 2)
//   ptr_o        PW     current priority pointer (debug)
// Modports: slave = arbiter side, master = requester/downstream side.
interface dual_grant_rr_arbiter_if #(
    parameter int WIDTH = 12
);
    localparam int PW = $clog2(WIDTH);

    logic [WIDTH-1:0] req_i;
    logic             gnt_ready_i;
    logic             gnt_valid_o;
    logic [WIDTH-1:0] gnt0_o;
    logic [WIDTH-1:0] gnt1_o;
    logic [1:0]       gnt_cnt_o;
    logic [PW-1:0]    ptr_o;

    modport slave (
        input  req_i,
        input  gnt_ready_i,
        output gnt_valid_o,
        output gnt0_o,
        output gnt1_o,
        output gnt_cnt_o,
        output ptr_o
    );

    modport master (
        output req_i,
        output gnt_ready_i,
        input  gnt_valid_o,
        input  gnt0_o,
        input  gnt1_o,
        input  gnt_cnt_o,
        input  ptr_o
    );
endinterface

// File: rtl/dual_grant_rr_arbiter.sv
// rtl/dual_grant_rr_arbiter.sv - round-robin arbiter granting up to two requesters per grant cycle
//
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  synchronous active-low reset
//   bus     dual_grant_rr_arbiter_if.slave: req_i in, valid/ready grant handshake out,
//           gnt0_o/gnt1_o one-hot grants, gnt_cnt_o grant count, ptr_o priority pointer
module dual_grant_rr_arbiter #(
    parameter int WIDTH = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    dual_grant_rr_arbiter_if.slave   bus
);
    localparam int PW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic             valid_q;
    logic [WIDTH-1:0] gnt0_q;
    logic [WIDTH-1:0] gnt1_q;
    logic [1:0]       cnt_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    last_q;

    // One extra bit so ptr + offset never overflows before the wrap compare.
    logic [PW:0]      idx;
    logic             found0;
    logic             found1;
    logic [PW-1:0]    g0_idx;
    logic [PW-1:0]    g1_idx;
    logic [PW-1:0]    ptr_next;

    // Walk the requesters in priority order starting at ptr_q and keep the
    // first two set bits. Wrap is by compare against WIDTH since WIDTH need
    // not be a power of two.
    always_comb begin
        idx    = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(WIDTH)) begin
                idx = idx - (PW+1)'(WIDTH);
            end
            if (bus.req_i[idx[PW-1:0]]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    g0_idx = idx[PW-1:0];
                end else if (!found1) begin
                    found1 = 1'b1;
                    g1_idx = idx[PW-1:0];
                end
            end
        end
    end

    // Priority moves to just past the last requester actually served.
    assign ptr_next = (last_q == PW'(WIDTH - 1)) ? '0 : last_q + PW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            gnt0_q  <= '0;
            gnt1_q  <= '0;
            cnt_q   <= 2'd0;
            ptr_q   <= '0;
            last_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found0) begin
                        valid_q <= 1'b1;
                        gnt0_q  <= WIDTH'(1) << g0_idx;
                        gnt1_q  <= found1 ? (WIDTH'(1) << g1_idx) : '0;
                        cnt_q   <= found1 ? 2'd2 : 2'd1;
                        last_q  <= found1 ? g1_idx : g0_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // Grant is held untouched until accepted; req_i is ignored here.
                    if (bus.gnt_ready_i) begin
                        valid_q <= 1'b0;
                        gnt0_q  <= '0;
                        gnt1_q  <= '0;
                        cnt_q   <= 2'd0;
                        ptr_q   <= ptr_next;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_valid_o = valid_q;
    assign bus.gnt0_o      = gnt0_q;
    assign bus.gnt1_o      = gnt1_q;
    assign bus.gnt_cnt_o   = cnt_q;
    assign bus.ptr_o       = ptr_q;
endmodule

// File: doc/dual_grant_rr_arbiter.md
Name: dual_grant_rr_arbiter

Overview:
Round-robin arbiter that grants up to two requesters per grant cycle, out of WIDTH request lines. It applies second-set-bit selection to a priority-rotated request vector, so the two oldest-priority active requesters are granted together. Grants are registered and presented on a valid/ready handshake to the downstream shared resource. It sits between the requester bank and the two-port shared resource that our second-bit-set datapath feeds.

Parameters:
WIDTH, 12, number of request lines; legal range is WIDTH >= 2, and it need not be a power of 2.
PW, $clog2(WIDTH), width of the priority pointer. Derived; do not override.

Ports:
clk_i  input  1  clock; all logic updates on the rising edge.
rst_ni  input  1  reset, synchronous, active-low.
req_i  input  WIDTH  request vector; bit k is requester k.
gnt_valid_o  output  1  a grant is being presented.
gnt_ready_i  input  1  downstream accepts the grant when it is high in the same cycle as gnt_valid_o.
gnt0_o  output  WIDTH  one-hot first grant; zero when no grant.
gnt1_o  output  WIDTH  one-hot second grant; zero when only one requester was granted.
gnt_cnt_o  output  2  number of grants presented: 0, 1 or 2.
ptr_o  output  PW  current priority pointer, for debug.

Behaviour:
- Reset: on a rising edge with rst_ni=0, the following values apply next cycle.
  - state=IDLE, gnt_valid_o=0, gnt0_o=0, gnt1_o=0, gnt_cnt_o=0, ptr_o=0.
  - Reset wins over all other events, including mid-GRANT; a pending grant is dropped.
- Priority order: search starts at index ptr and goes ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1.
  - Wrap is done by compare against WIDTH, not by modulo-2^PW.
- FSM has two states, IDLE and GRANT.
- In IDLE, when req_i == 0:
  - Stay in IDLE; all outputs stay 0.
- In IDLE, when req_i != 0, the following take effect next edge:
  - g0 = first set bit of req_i in priority order.
  - g1 = next set bit after g0 in priority order; none if req_i has a single bit set.
  - gnt0_o = onehot(g0); gnt1_o = onehot(g1) or 0.
  - gnt_cnt_o = 2 or 1; gnt_valid_o=1; state -> GRANT.
  - Latency: 1 cycle from req_i sampled to gnt_valid_o high.
- In GRANT, while gnt_ready_i=0:
  - gnt_valid_o, gnt0_o, gnt1_o, gnt_cnt_o and ptr_o are held stable.
  - req_i is ignored, including deassertion of granted lines; a grant is never withdrawn.
- In GRANT, when gnt_ready_i=1 (accept), the following take effect next edge:
  - ptr <= (last granted index + 1), wrapping at WIDTH to 0.
  - The last granted index is g1 if gnt_cnt_o=2, else g0.
  - gnt_valid_o=0; gnt0_o, gnt1_o and gnt_cnt_o cleared to 0; state -> IDLE.
- Throughput: at most one grant per 2 cycles. IDLE always lasts at least one cycle after an accept.
- gnt_ready_i is ignored in IDLE.
- Invariants:
  - gnt0_o and gnt1_o are never equal when nonzero.
  - (gnt0_o | gnt1_o) is always a subset of the req_i sampled at grant time.
  - gnt_cnt_o == popcount(gnt0_o | gnt1_o).
- X-safety: no output is X after the first reset edge.

Test Plan:
1. Reset: hold rst_ni=0 for 2 edges with req_i=12'hFFF -> gnt_valid_o=0, gnt0_o=0, gnt1_o=0, gnt_cnt_o=0, ptr_o=0.
2. Basic pair: ptr=0, req_i=12'b001001000000.
   - Next cycle: gnt_valid_o=1, gnt0_o=12'b000001000000, gnt1_o=12'b001000000000, gnt_cnt_o=2.
   - Ready=1: ptr_o=10 next cycle, gnt_valid_o=0.
3. Wrap and fairness: from ptr=10, req_i=12'b111100001111.
   - First grant: gnt0_o=bit10, gnt1_o=bit11, accept -> ptr_o=0.
   - Second grant: gnt0_o=bit0, gnt1_o=bit1, accept -> ptr_o=2.
   - Cross-boundary case: ptr=6, req_i bits {11,2} -> gnt0_o=bit11, gnt1_o=bit2, accept -> ptr_o=3.
4. Single and empty:
   - req_i=12'b000000100000 -> gnt0_o=bit5, gnt1_o=0, gnt_cnt_o=1, accept -> ptr_o=6.
   - req_i=0 for 5 cycles -> gnt_valid_o stays 0 and ptr_o is unchanged.
5. Backpressure: hold gnt_ready_i=0 for 6 cycles while toggling req_i randomly -> gnt0_o, gnt1_o, gnt_cnt_o and ptr_o are identical every cycle; on accept, ptr_o updates from the held grant.
6. Reset mid-GRANT: drive gnt_valid_o=1 with ptr=6, then assert rst_ni=0 for 1 edge -> next cycle all outputs 0 and ptr_o=0; after release, req_i=12'b000000000011 -> gnt0_o=bit0, gnt1_o=bit1.
